vga_timing_pipeline: RTL and testbench



---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_delay_line.sv | 33 +++
 rtl/vga_timing_pipeline.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_pipeline.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_pkg : 640x480@60 default timing, coordinate width, and helpers.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package vga_pkg;

  localparam int COORD_W       = 11;
  localparam int MAX_TOTAL     = 2048;
  localparam int MAX_FETCH_LAT = 7;

  localparam int VGA640_H_VISIBLE = 640;
  localparam int VGA640_H_FP      = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BP      = 48;
  localparam int VGA640_V_VISIBLE = 480;
  localparam int VGA640_V_FP      = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BP      = 33;

  function automatic int h_total(input int visible, input int fp, input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  function automatic int v_total(input int visible, input int fp, input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  // {R,G,B} on/off for bar index 0..7: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
    case (bar)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_delay_line : DEPTH-stage shift register with a per-bit reset value.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= {DEPTH{RESET_VAL}};
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_pipeline : parametrised VGA counters, sync generation and a   |
// | colour output stage aligned to a FETCH_LAT-cycle pixel source.           |
// | Optional build macro: VGA_TEST_PATTERN_EN (8-bar colour test pattern).   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vga_timing_pipeline
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA640_H_VISIBLE,
  parameter int H_FP      = VGA640_H_FP,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BP      = VGA640_H_BP,
  parameter int V_VISIBLE = VGA640_V_VISIBLE,
  parameter int V_FP      = VGA640_V_FP,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BP      = VGA640_V_BP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int COLOR_W   = 8,
  parameter int FETCH_LAT = 1
) (
  input  logic                 vga_clk,
  input  logic                 reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_en,
`endif
  input  logic [3*COLOR_W-1:0] pixel,
  output logic [COORD_W-1:0]   next_pixel_h,
  output logic [COORD_W-1:0]   next_pixel_v,
  output logic                 next_valid,
  output logic                 frame_start,
  output logic                 blank_n,
  output logic                 HS,
  output logic                 VS,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || FETCH_LAT < 0 || FETCH_LAT > MAX_FETCH_LAT) begin : g_bad_params
      $error("vga_timing_pipeline: line/frame totals must be <= 2048 and FETCH_LAT within 0..7");
    end
  endgenerate

  // One extra bit so boundaries equal to 2048 still compare correctly
  localparam int                 XW       = COORD_W + 1;
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [XW-1:0]      H_VIS_X  = XW'(H_VISIBLE);
  localparam logic [XW-1:0]      V_VIS_X  = XW'(V_VISIBLE);
  localparam logic [XW-1:0]      HS_START = XW'(H_VISIBLE + H_FP);
  localparam logic [XW-1:0]      HS_END   = XW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [XW-1:0]      VS_START = XW'(V_VISIBLE + V_FP);
  localparam logic [XW-1:0]      VS_END   = XW'(V_VISIBLE + V_FP + V_SYNC);

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic [XW-1:0]      h_ext;
  logic [XW-1:0]      v_ext;
  logic               visible;
  logic               hs_level;
  logic               vs_level;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign h_ext    = {1'b0, h_cnt};
  assign v_ext    = {1'b0, v_cnt};
  assign visible  = (h_ext < H_VIS_X) && (v_ext < V_VIS_X);
  assign hs_level = (h_ext >= HS_START && h_ext < HS_END) ? HS_POL : ~HS_POL;
  assign vs_level = (v_ext >= VS_START && v_ext < VS_END) ? VS_POL : ~VS_POL;

  assign next_pixel_h = h_cnt;
  assign next_pixel_v = v_cnt;
  assign next_valid   = visible;
  // Gated by reset so the pulse marks the first real cycle, not the held reset state
  assign frame_start  = ~reset && (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_TEST_PATTERN_EN
  localparam int              DL_W     = 3 + COORD_W;
  localparam logic [DL_W-1:0] DL_RESET = {{COORD_W{1'b0}}, ~VS_POL, ~HS_POL, 1'b0};
`else
  localparam int              DL_W     = 3;
  localparam logic [DL_W-1:0] DL_RESET = {~VS_POL, ~HS_POL, 1'b0};
`endif

  logic [DL_W-1:0] dl_in;
  logic [DL_W-1:0] dl_out;

`ifdef VGA_TEST_PATTERN_EN
  assign dl_in = {h_cnt, vs_level, hs_level, visible};
`else
  assign dl_in = {vs_level, hs_level, visible};
`endif

  // First FETCH_LAT stages live in the delay line; the last stage is the output register below
  generate
    if (FETCH_LAT == 0) begin : g_no_delay
      assign dl_out = dl_in;
    end else begin : g_delay
      vga_delay_line #(
        .WIDTH     (DL_W),
        .DEPTH     (FETCH_LAT),
        .RESET_VAL (DL_RESET)
      ) u_delay (
        .clk  (vga_clk),
        .rst  (reset),
        .din  (dl_in),
        .dout (dl_out)
      );
    end
  endgenerate

  logic [3*COLOR_W-1:0] color_next;
  logic [3*COLOR_W-1:0] color_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;

  logic [COORD_W-1:0] fetch_h;
  logic [COORD_W-1:0] bar_raw;
  logic [2:0]         bar_idx;
  logic [2:0]         bar_on;

  assign fetch_h = dl_out[DL_W-1:3];
  assign bar_raw = fetch_h / COORD_W'(BAR_W);
  assign bar_idx = (bar_raw > COORD_W'(7)) ? 3'd7 : bar_raw[2:0];
  assign bar_on  = bar_rgb(bar_idx);
`endif

  always_comb begin
    color_next = '0;
    if (dl_out[0]) begin
`ifdef VGA_TEST_PATTERN_EN
      if (test_en) begin
        color_next = {{COLOR_W{bar_on[2]}}, {COLOR_W{bar_on[1]}}, {COLOR_W{bar_on[0]}}};
      end else begin
        color_next = pixel;
      end
`else
      color_next = pixel;
`endif
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      color_q <= '0;
      blank_n <= 1'b0;
      HS      <= ~HS_POL;
      VS      <= ~VS_POL;
    end else begin
      color_q <= color_next;
      blank_n <= dl_out[0];
      HS      <= dl_out[1];
      VS      <= dl_out[2];
    end
  end

  assign red   = color_q[3*COLOR_W-1:2*COLOR_W];
  assign green = color_q[2*COLOR_W-1:COLOR_W];
  assign blue  = color_q[COLOR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_timing_pipeline : directed checks on three timing configurations. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vga_timing_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // A: default 640x480, FETCH_LAT=1
  logic        rst_a = 1'b1;
  logic [23:0] pix_a = 24'h123456;
  logic [10:0] ha, va;
  logic        nva, fsa, bna, hsa, vsa;
  logic [7:0]  ra, ga, ba;
  // B: tiny 12x7 timing, positive syncs, FETCH_LAT=0
  logic        rst_b = 1'b1;
  logic [23:0] pix_b = 24'hFFFFFF;
  logic [10:0] hb, vb;
  logic        nvb, fsb, bnb, hsb, vsb;
  logic [7:0]  rb, gb, bb;
  // C: 23x10 timing, FETCH_LAT=2 with a two-stage source model
  logic        rst_c = 1'b1;
  logic [23:0] pc1, pc2;
  logic [10:0] hc, vc;
  logic        nvc, fsc, bnc, hsc, vsc;
  logic [7:0]  rc, gc, bc;
`ifdef VGA_TEST_PATTERN_EN
  logic        ten_a = 1'b0;
  logic        ten_0 = 1'b0;
`endif

  always @(posedge clk) begin
    pc1 <= {hc[7:0], vc[7:0], 8'hA5};
    pc2 <= pc1;
  end

  vga_timing_pipeline #(.FETCH_LAT(1)) u_a (
    .vga_clk(clk), .reset(rst_a),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(ten_a),
`endif
    .pixel(pix_a), .next_pixel_h(ha), .next_pixel_v(va), .next_valid(nva),
    .frame_start(fsa), .blank_n(bna), .HS(hsa), .VS(vsa), .red(ra), .green(ga), .blue(ba));

  vga_timing_pipeline #(.H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                        .HS_POL(1'b1), .VS_POL(1'b1), .FETCH_LAT(0)) u_b (
    .vga_clk(clk), .reset(rst_b),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(ten_0),
`endif
    .pixel(pix_b), .next_pixel_h(hb), .next_pixel_v(vb), .next_valid(nvb),
    .frame_start(fsb), .blank_n(bnb), .HS(hsb), .VS(vsb), .red(rb), .green(gb), .blue(bb));

  vga_timing_pipeline #(.H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
                        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                        .FETCH_LAT(2)) u_c (
    .vga_clk(clk), .reset(rst_c),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(ten_0),
`endif
    .pixel(pc2), .next_pixel_h(hc), .next_pixel_v(vc), .next_valid(nvc),
    .frame_start(fsc), .blank_n(bnc), .HS(hsc), .VS(vsc), .red(rc), .green(gc), .blue(bc));

  int e_ahs = 0, e_abn = 0, e_argb = 0;
  int e_bhs = 0, e_bvs = 0, e_bbn = 0, e_brgb = 0;
  int e_cbn = 0, e_cvs = 0, e_crgb = 0;
  int b_hs_line0 = 0, b_vs_frame0 = 0;
  int c_fs_n = 0, c_fs_2nd = -1;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("A_rst_blank", bna, 0);
    check("A_rst_hs", hsa, 1);
    check("A_rst_vs", vsa, 1);
    check("A_rst_rgb", {ra, ga, ba}, 0);
    check("A_rst_fs", fsa, 0);
    check("B_rst_hs", hsb, 0);
    check("B_rst_vs", vsb, 0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    for (int c = 0; c < 1700; c++) begin
      int m, p, h, v;
      logic bn_e, hs_e, vs_e;
      @(negedge clk);
      // A: L=2, 800-cycle lines
      m = c % 800;
      hs_e = !(m >= 658 && m <= 753);
      bn_e = (m >= 2 && m <= 641);
      if (hsa !== hs_e) e_ahs++;
      if (bna !== bn_e) e_abn++;
      if ({ra, ga, ba} !== (bn_e ? 24'h123456 : 24'h0)) e_argb++;
      // B: L=1, 12x7 frame
      if (c >= 1) begin
        p = c - 1; h = p % 12; v = (p / 12) % 7;
        hs_e = (h == 9 || h == 10); vs_e = (v == 5); bn_e = (h < 8 && v < 4);
      end else begin
        hs_e = 1'b0; vs_e = 1'b0; bn_e = 1'b0;
      end
      if (hsb !== hs_e) e_bhs++;
      if (vsb !== vs_e) e_bvs++;
      if (bnb !== bn_e) e_bbn++;
      if ({rb, gb, bb} !== (bn_e ? 24'hFFFFFF : 24'h0)) e_brgb++;
      if (c >= 1 && c <= 12 && hsb) b_hs_line0++;
      if (c >= 1 && c <= 84 && vsb) b_vs_frame0++;
      // C: L=3, 23x10 frame
      if (c >= 3) begin
        p = c - 3; h = p % 23; v = (p / 23) % 10;
        bn_e = (h < 16 && v < 6); vs_e = !(v == 7 || v == 8);
      end else begin
        h = 0; v = 0; bn_e = 1'b0; vs_e = 1'b1;
      end
      if (bnc !== bn_e) e_cbn++;
      if (vsc !== vs_e) e_cvs++;
      if ({rc, gc, bc} !== (bn_e ? {h[7:0], v[7:0], 8'hA5} : 24'h0)) e_crgb++;
      if (c < 460 && fsc) begin
        c_fs_n++;
        if (c > 0) c_fs_2nd = c;
      end
      case (c)
        0:    begin check("A_fs_c0", fsa, 1); check("A_h_c0", ha, 0); end
        1:    begin check("A_fs_c1", fsa, 0); check("A_blank_c1", bna, 0); end
        2:    begin check("A_blank_c2", bna, 1); check("A_red_c2", ra, 8'h12); end
        3:    check("C_rgb_c3", {rc, gc, bc}, 24'h0000A5);
        9:    check("B_hs_c9", hsb, 0);
        10:   check("B_hs_c10", hsb, 1);
        11:   check("B_hs_c11", hsb, 1);
        12:   check("B_hs_c12", hsb, 0);
        18:   check("C_red_c18", rc, 8'h0F);
        19:   begin check("C_blank_c19", bnc, 0); check("C_rgb_c19", {rc, gc, bc}, 0); end
        60:   check("B_vs_c60", vsb, 0);
        61:   check("B_vs_c61", vsb, 1);
        72:   check("B_vs_c72", vsb, 1);
        73:   check("B_vs_c73", vsb, 0);
        83:   check("B_fs_c83", fsb, 0);
        84:   check("B_fs_c84", fsb, 1);
        125:  check("C_rgb_c125", {rc, gc, bc}, 24'h0705A5);
        639:  check("A_valid_c639", nva, 1);
        640:  check("A_valid_c640", nva, 0);
        641:  check("A_blank_c641", bna, 1);
        642:  begin check("A_blank_c642", bna, 0); check("A_rgb_c642", {ra, ga, ba}, 0); end
        657:  check("A_hs_c657", hsa, 1);
        658:  check("A_hs_c658", hsa, 0);
        700:  check("A_h_c700", ha, 700);
        753:  check("A_hs_c753", hsa, 0);
        754:  check("A_hs_c754", hsa, 1);
        800:  begin check("A_h_c800", ha, 0); check("A_v_c800", va, 1); end
        default: ;
      endcase
      @(posedge clk); #1;
    end
    check("A_hs_errs", e_ahs, 0);
    check("A_blank_errs", e_abn, 0);
    check("A_rgb_errs", e_argb, 0);
    check("B_hs_errs", e_bhs, 0);
    check("B_vs_errs", e_bvs, 0);
    check("B_blank_errs", e_bbn, 0);
    check("B_rgb_errs", e_brgb, 0);
    check("B_hs_per_line", b_hs_line0, 2);
    check("B_vs_per_frame", b_vs_frame0, 12);
    check("C_blank_errs", e_cbn, 0);
    check("C_vs_errs", e_cvs, 0);
    check("C_rgb_errs", e_crgb, 0);
    check("C_fs_count", c_fs_n, 2);
    check("C_fs_period", c_fs_2nd, 230);

    // Mid-frame reset on C at address h=5, v=3
    rst_c = 1'b1;
    @(posedge clk); #1;
    rst_c = 1'b0;
    for (int c = 0; c < 74; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("C_pre_h", hc, 5);
    check("C_pre_v", vc, 3);
    rst_c = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("C_rst_blank", bnc, 0);
    check("C_rst_rgb", {rc, gc, bc}, 0);
    check("C_rst_hs", hsc, 1);
    check("C_rst_vs", vsc, 1);
    check("C_rst_hv", {hc, vc}, 0);
    @(posedge clk); #1;
    rst_c = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) check("C_rel_fs", fsc, 1);
      check($sformatf("C_rel_blank%0d", c), bnc, (c == 3) ? 1 : 0);
      if (c < 3) check($sformatf("C_rel_rgb%0d", c), {rc, gc, bc}, 0);
      else       check("C_rel_rgb3", {rc, gc, bc}, 24'h0000A5);
      @(posedge clk); #1;
    end

`ifdef VGA_TEST_PATTERN_EN
    rst_a = 1'b1;
    ten_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    for (int c = 0; c < 643; c++) begin
      @(negedge clk);
      case (c)
        2:   check("TP_h0", {ra, ga, ba}, 24'hFFFFFF);
        82:  check("TP_h80", {ra, ga, ba}, 24'hFFFF00);
        202: check("TP_h200", {ra, ga, ba}, 24'h00FFFF);
        561: check("TP_h559", {ra, ga, ba}, 24'h0000FF);
        641: check("TP_h639", {ra, ga, ba}, 24'h000000);
        642: check("TP_blank", bna, 0);
        default: ;
      endcase
      @(posedge clk); #1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
